// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port arbiter/sequencer in front of data_memory.
// Port 0 (MEM stage) has priority; port 1 (debug/DMA loader) is guaranteed a
// slot after STARVE_MAX consecutive denials. Three-stage flow per access:
//   G (grant + register cmd) -> A (drive mem_*, sample rdata) -> D (done pulse)
// A new access may be granted every cycle.
// Optional build macro DMA_ADDR_CHECK_EN: accesses outside [ADDR_LO, ADDR_HI]
// are not issued to memory and complete with err=1.
module data_mem_arbiter #(
  parameter int              AW         = 32,
  parameter int              DW         = 32,
  parameter int              STARVE_MAX = 4,
  parameter logic [AW-1:0]   ADDR_LO    = AW'(32'h7fff_feff),
  parameter logic [AW-1:0]   ADDR_HI    = AW'(32'h7fff_ffff)
) (
  input  logic          clk,
  input  logic          rst_n,
  // port 0: pipeline MEM stage
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_gnt,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  // port 1: debug/DMA loader
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_gnt,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  // data_memory side
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int         STAGES     = 2;               // A and D behind G
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

`ifdef DMA_ADDR_CHECK_EN
  localparam logic ADDR_CHECK = 1'b1;
`else
  // No range check: err is constant 0 and every access is issued.
  localparam logic ADDR_CHECK = 1'b0;
`endif

  typedef struct packed {
    logic          port;   // 0 = port 0, 1 = port 1
    logic          we;
    logic          err;    // out-of-range, suppresses the memory access
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  logic              gnt0, gnt1;
  cmd_t              g_cmd;

  logic [3:0]        starve_cnt_q, starve_cnt_d;
  logic [STAGES-1:0] vld_pipe_q, vld_pipe_d;   // [0] = A occupied, [1] = D occupied
  cmd_t              a_cmd_q, a_cmd_d;
  logic              d_port_q, d_port_d;
  logic              d_err_q, d_err_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;

  // Arbitration: port 0 first unless port 1 has waited STARVE_MAX cycles.
  always_comb begin
    gnt0 = rst_n & p0_req & (starve_cnt_q < STARVE_LIM);
    gnt1 = rst_n & p1_req & ~gnt0;
  end

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  // Select the winning command and tag it with its range-check result.
  always_comb begin
    g_cmd       = '0;
    g_cmd.port  = gnt1;
    g_cmd.we    = gnt1 ? p1_we    : p0_we;
    g_cmd.addr  = gnt1 ? p1_addr  : p0_addr;
    g_cmd.wdata = gnt1 ? p1_wdata : p0_wdata;
    g_cmd.err   = ADDR_CHECK & ((g_cmd.addr < ADDR_LO) | (g_cmd.addr > ADDR_HI));
  end

  // Starvation counter: counts port-1 denials, clears on grant or idle.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!p1_req || gnt1)
      starve_cnt_d = '0;
    else if (starve_cnt_q < STARVE_LIM)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  // Pipeline advance: G -> A holds the cmd (mem_addr/mem_wdata hold when idle),
  // A -> D captures read data or zero for writes and faulted accesses.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[0], gnt0 | gnt1};
    a_cmd_d    = a_cmd_q;
    if (gnt0 | gnt1)
      a_cmd_d = g_cmd;
    d_port_d  = a_cmd_q.port;
    d_err_d   = vld_pipe_q[0] & a_cmd_q.err;
    d_rdata_d = '0;
    if (vld_pipe_q[0] && !a_cmd_q.we && !a_cmd_q.err)
      d_rdata_d = mem_rdata;
  end

  // State registers with synchronous active-low reset; reset discards all in-flight work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
      vld_pipe_q   <= '0;
      a_cmd_q      <= '0;
      d_port_q     <= 1'b0;
      d_err_q      <= 1'b0;
      d_rdata_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      vld_pipe_q   <= vld_pipe_d;
      a_cmd_q      <= a_cmd_d;
      d_port_q     <= d_port_d;
      d_err_q      <= d_err_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // A-stage memory drive: write strobe only for an issued write.
  always_comb begin
    mem_we    = vld_pipe_q[0] & a_cmd_q.we & ~a_cmd_q.err;
    mem_addr  = a_cmd_q.addr;
    mem_wdata = a_cmd_q.wdata;
  end

  // D-stage completion routed to the owning port; the other port sees zeros.
  always_comb begin
    p0_done  = vld_pipe_q[1] & ~d_port_q;
    p1_done  = vld_pipe_q[1] &  d_port_q;
    p0_rdata = p0_done ? d_rdata_q : '0;
    p1_rdata = p1_done ? d_rdata_q : '0;
    p0_err   = p0_done & d_err_q;
    p1_err   = p1_done & d_err_q;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Testbench for data_mem_arbiter: directed reset / write-read / reset-mid-access
// sequences followed by randomized traffic, checked by a scoreboard fed from a
// behavioural model of arbitration and of the attached 256-word memory.
module tb_data_mem_arbiter;
  localparam int SMAX = 4;
  localparam logic [31:0] LO = 32'h7fff_feff;
  localparam logic [31:0] HI = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p0_done, p0_err, p1_gnt, p1_done, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  data_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(SMAX), .ADDR_LO(LO), .ADDR_HI(HI)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Attached data memory: 256 words indexed by addr[7:0], combinational read.
  function automatic logic [31:0] init_val(input logic [7:0] a);
    return {8'hA5, a, ~a, 8'h3C};
  endfunction

  bit [31:0] env_mem [256];
  bit        env_wr  [256];
  always @(posedge clk) if (mem_we) begin
    env_mem[mem_addr[7:0]] <= mem_wdata;
    env_wr[mem_addr[7:0]]  <= 1'b1;
  end
  assign mem_rdata = env_wr[mem_addr[7:0]] ? env_mem[mem_addr[7:0]] : init_val(mem_addr[7:0]);

  typedef struct {
    int          port;
    bit          we;
    bit          err;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cyc;
  } acc_t;

  acc_t sbq[$];   // awaiting done (D stage)
  acc_t aq[$];    // awaiting memory drive (A stage)
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
    end
  endtask

  // Monitor + reference model: checks A and D stages, predicts grants, feeds queues.
  initial begin
    logic [31:0] ref_mem [256];
    int          cnt = 0;
    logic [31:0] last_a = '0, last_w = '0;
    bit          e0, e1;
    acc_t        e;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
    forever begin
      @(negedge clk);
      cyc++;
      // A stage: an access granted last cycle drives memory now, else hold
      if (aq.size() > 0 && aq[0].cyc + 1 == cyc) begin
        e = aq.pop_front();
        chk("mem_we",    32'(mem_we), 32'(e.we && !e.err));
        chk("mem_addr",  mem_addr,  e.addr);
        chk("mem_wdata", mem_wdata, e.wdata);
        last_a = e.addr;
        last_w = e.wdata;
      end else begin
        chk("mem_we_idle",    32'(mem_we), 32'd0);
        chk("mem_addr_hold",  mem_addr,  last_a);
        chk("mem_wdata_hold", mem_wdata, last_w);
      end
      // D stage
      while (sbq.size() > 0 && sbq[0].cyc + 2 < cyc) begin
        e = sbq.pop_front();
        tests++; fails++;
        $display("FAIL done_missing cyc=%0d got=none exp=port%0d grant@%0d", cyc, e.port, e.cyc);
      end
      if (sbq.size() > 0 && sbq[0].cyc + 2 == cyc) begin
        e = sbq.pop_front();
        chk("p0_done",  32'(p0_done), 32'(e.port == 0));
        chk("p1_done",  32'(p1_done), 32'(e.port == 1));
        chk("p0_rdata", p0_rdata, (e.port == 0) ? e.rdata : 32'd0);
        chk("p1_rdata", p1_rdata, (e.port == 1) ? e.rdata : 32'd0);
        chk("p0_err",   32'(p0_err), 32'(e.port == 0 && e.err));
        chk("p1_err",   32'(p1_err), 32'(e.port == 1 && e.err));
      end else begin
        chk("p0_done_idle",  32'(p0_done), 32'd0);
        chk("p1_done_idle",  32'(p1_done), 32'd0);
        chk("p0_rdata_idle", p0_rdata, 32'd0);
        chk("p1_rdata_idle", p1_rdata, 32'd0);
        chk("p0_err_idle",   32'(p0_err), 32'd0);
        chk("p1_err_idle",   32'(p1_err), 32'd0);
      end
      // G stage prediction
      e0 = rst_n && p0_req && (cnt < SMAX);
      e1 = rst_n && !e0 && p1_req;
      chk("p0_gnt", 32'(p0_gnt), 32'(e0));
      chk("p1_gnt", 32'(p1_gnt), 32'(e1));
      if (!rst_n) begin
        sbq.delete(); aq.delete();
        cnt = 0; last_a = '0; last_w = '0;
      end else begin
        if (!p1_req || e1) cnt = 0;
        else if (cnt < SMAX) cnt++;
        if (e0 || e1) begin
          e.port  = e1 ? 1 : 0;
          e.we    = e1 ? p1_we    : p0_we;
          e.addr  = e1 ? p1_addr  : p0_addr;
          e.wdata = e1 ? p1_wdata : p0_wdata;
          e.cyc   = cyc;
`ifdef DMA_ADDR_CHECK_EN
          e.err = (e.addr < LO) || (e.addr > HI);
`else
          e.err = 1'b0;
`endif
          e.rdata = '0;
          if (!e.err) begin
            if (e.we) ref_mem[e.addr[7:0]] = e.wdata;
            else      e.rdata = ref_mem[e.addr[7:0]];
          end
          sbq.push_back(e);
          aq.push_back(e);
        end
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) begin
      case ($urandom_range(0, 3))
        0:       return 32'h0000_0010;
        1:       return 32'h7fff_fefe;
        2:       return 32'h7fff_feff;
        default: return 32'h8000_0000;
      endcase
    end
    if (r < 5) return {29'h0fff_ffe0, 3'($urandom_range(0, 7))};
    return {24'h7fffff, 8'($urandom_range(0, 255))};
  endfunction

  task automatic new_cmd(input int port, input int dens);
    bit          rq = ($urandom_range(0, 99) < dens);
    bit          w  = 1'($urandom_range(0, 1));
    logic [31:0] a  = rand_addr();
    logic [31:0] d  = $urandom;
    if (port == 0) begin p0_req = rq; p0_we = w; p0_addr = a; p0_wdata = d; end
    else           begin p1_req = rq; p1_we = w; p1_addr = a; p1_wdata = d; end
  endtask

  // Present one request, hold it until granted (bounded), then drop it.
  task automatic issue(input int port, input bit we, input logic [31:0] a, input logic [31:0] d);
    bit got = 1'b0;
    if (port == 0) begin p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d; end
    else           begin p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d; end
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      got = (port == 0) ? p0_gnt : p1_gnt;
      @(posedge clk); #1;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL grant_timeout port%0d got=no_grant exp=grant", port);
    end
  endtask

  // Stimulus
  initial begin
    bit g0, g1;
    int dens;
    rst_n = 1'b0;
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h7fff_ff00; p0_wdata = 32'h1111_1111;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h7fff_ff04; p1_wdata = 32'h2222_2222;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; p0_req = 1'b0; p1_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // write then read back, p1 read, p1 out-of-range write
    issue(0, 1'b1, 32'h7fff_ff00, 32'hDEAD_BEEF);
    issue(0, 1'b0, 32'h7fff_ff00, 32'h0);
    issue(1, 1'b0, 32'h7fff_fff0, 32'h0);
    issue(1, 1'b1, 32'h0000_0010, 32'h1234_5678);
    repeat (4) @(posedge clk);
    #1;
    // reset in the A cycle of a granted write
    issue(0, 1'b1, 32'h7fff_ff20, 32'hCAFE_F00D);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    // random traffic: mixed, saturated (starvation pattern), mixed with resets
    for (int ph = 0; ph < 3; ph++) begin
      dens = (ph == 1) ? 100 : (ph == 0 ? 60 : 70);
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        g0 = p0_gnt; g1 = p1_gnt;
        @(posedge clk); #1;
        if (ph == 2 && rst_n && $urandom_range(0, 39) == 0) rst_n = 1'b0;
        else rst_n = 1'b1;
        if (!p0_req || g0) new_cmd(0, dens);
        else if (ph != 1 && $urandom_range(0, 19) == 0) p0_req = 1'b0;
        if (!p1_req || g1) new_cmd(1, dens);
        else if (ph != 1 && $urandom_range(0, 19) == 0) p1_req = 1'b0;
      end
      p0_req = 1'b0; p1_req = 1'b0; rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;
    end
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
